l2_cache_control: RTL and testbench
===================================

L2_CACHE_CONTROL -- requirements
Module: l2_cache_control

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports mem_read and mem_write, input, 1 each, upstream request; held until mem_resp; never both high.
REQ-004 SHALL have port mem_resp, output, 1, one-cycle completion pulse to upstream.
REQ-005 SHALL have ports pmem_read and pmem_write, output, 1 each, and pmem_resp, input, 1, the memory-side handshake.
REQ-006 SHALL have ports hit (in, 1), way_hit (in, 8), valid_out (in, 8), dirty_out (in, 8) and plru (in, 3), the datapath status.
REQ-007 SHALL have ports way_load, valid_load, valid_in, dirty_load, dirty_in (out, 8 each), lru_load (out, 1) and mru (out, 3), the datapath array controls.
REQ-008 SHALL have ports way_sel (out, 3), pmem_address_sel (out, pmem_addr_mux_sel_t), way_data_in_sel[8] (out, data_in_mux_sel_t) and way_write_en_sel[8] (out, data_write_en_mux_sel_t).
REQ-009 SHALL have ports hit_count and miss_count, output, 32 each, saturating performance counters.

Function
REQ-010 SHALL implement states IDLE, CHECK, WRITEBACK and FILL.
REQ-011 IDLE: mem_read|mem_write -> CHECK next cycle; otherwise stay; all outputs at default.
REQ-012 Defaults in every state unless overridden: all loads 0, way_write_en_sel idle, way_data_in_sel cacheline_adaptor, pmem_address_sel cpu, mem_resp/pmem_read/pmem_write 0.
REQ-013 CHECK with hit: mem_resp=1, lru_load=1, mru=encoded way_hit, way_sel=encoded way_hit, hit_count+1, -> IDLE.
REQ-014 CHECK hit on a write: the hit way gets way_data_in_sel bus_adaptor and way_write_en_sel cpu_write, with dirty_load=1 and dirty_in=1 for that way, in the same cycle.
REQ-015 CHECK miss: register victim = lowest-index way with valid_out=0, else plru; miss_count+1; -> WRITEBACK if victim valid and dirty, else FILL.
REQ-016 The miss count SHALL increment once per request, not again on the post-fill re-CHECK (tracked by a refill flag).
REQ-017 WRITEBACK: pmem_write=1, way_sel=victim, pmem_address_sel=dirty_<victim>_write; stay until pmem_resp, then -> FILL.
REQ-018 FILL: pmem_read=1, pmem_address_sel=cpu, victim way_data_in_sel=cacheline_adaptor.
REQ-019 FILL on pmem_resp: victim gets way_write_en_sel load_mem, way_load=1, valid_load=valid_in=1, dirty_load=1, dirty_in=0; -> CHECK.
REQ-020 Latency: hit responds 2 cycles after request; clean miss 2 + fill wait + 2; dirty miss adds the writeback wait.
REQ-021 pmem_read and pmem_write SHALL never be high together, and both are held high until pmem_resp.
REQ-022 Counters SHALL saturate at 32'hFFFFFFFF; no wrap.
REQ-023 mem_resp SHALL never be asserted outside CHECK.

Reset
REQ-024 rst SHALL force IDLE, clear the victim, refill flag and both counters, and drive all outputs to REQ-012 defaults the next cycle.
REQ-025 rst in WRITEBACK/FILL SHALL abandon the transaction, deassert pmem_read/pmem_write next cycle, and write no arrays.
REQ-026 rst SHALL take priority over all simultaneous events, including pmem_resp.

Structure
REQ-027 The state enum SHALL live in a shared package l2_ctrl_types; the mux select enums come from the existing pmem_addr_mux, data_in_mux and data_write_en_mux packages.
REQ-028 Victim choice and one-hot-to-binary encoding SHALL be one combinational sub-module, l2_victim_sel (inputs valid_out, dirty_out, plru; outputs victim[2:0], victim_dirty).

Verification
REQ-029 Read hit on way 5 (way_hit=8'h20) -> mem_resp on the 2nd cycle, mru=3'd5, lru_load=1, hit_count=1.
REQ-030 Write hit on way 2 -> way_write_en_sel[2]=cpu_write, way_data_in_sel[2]=bus_adaptor, dirty_load=dirty_in=8'h04.
REQ-031 Miss with valid_out=8'hF7 -> victim 3, no writeback, FILL; on pmem_resp valid_load=way_load=8'h08; re-CHECK hit; miss_count=1.
REQ-032 Miss with valid_out=8'hFF, dirty_out=8'h40, plru=6 -> pmem_address_sel=dirty_6_write and pmem_write until pmem_resp, then FILL.
REQ-033 rst asserted 3 cycles into FILL -> IDLE next cycle, pmem_read=0, counters 0, no array load.
REQ-034 hit_count preset at 32'hFFFFFFFF plus one more hit -> stays 32'hFFFFFFFF.

Source files
------------

// File: rtl/l2_cache_control_pkg.sv
// Shared types for the L2 cache controller: datapath mux selects, FSM state and counter helpers.
// The mux select packages describe the datapath's existing mux encodings.
package pmem_addr_mux;
  typedef enum logic [3:0] {
    cpu,
    dirty_0_write,
    dirty_1_write,
    dirty_2_write,
    dirty_3_write,
    dirty_4_write,
    dirty_5_write,
    dirty_6_write,
    dirty_7_write
  } pmem_addr_mux_sel_t;
endpackage

package data_in_mux;
  typedef enum logic {
    cacheline_adaptor,
    bus_adaptor
  } data_in_mux_sel_t;
endpackage

package data_write_en_mux;
  typedef enum logic [1:0] {
    idle,
    load_mem,
    cpu_write
  } data_write_en_mux_sel_t;
endpackage

package l2_ctrl_types;
  localparam int unsigned NumWays = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StWriteback,
    StFill
  } l2_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] count);
    return (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
  endfunction

  // dirty_N_write encodings follow cpu in order, so the way index maps directly.
  function automatic pmem_addr_mux::pmem_addr_mux_sel_t dirty_write_sel(input logic [2:0] way);
    return pmem_addr_mux::pmem_addr_mux_sel_t'({1'b0, way} + 4'd1);
  endfunction
endpackage

// File: rtl/l2_cache_control_victim_sel.sv
// Combinational victim choice for a miss and one-hot-to-binary encoding of the hit way.
module l2_victim_sel
  import l2_ctrl_types::*;
(
  input  logic [NumWays-1:0] valid_out,
  input  logic [NumWays-1:0] dirty_out,
  input  logic [NumWays-1:0] way_hit,
  input  logic [2:0]         plru,
  output logic [2:0]         victim,
  output logic               victim_dirty,
  output logic [2:0]         hit_way
);

  // Scan downwards so the lowest-index invalid way wins; plru only when every way is valid.
  always_comb begin
    victim = plru;
    for (int i = NumWays - 1; i >= 0; i--) begin
      if (!valid_out[i]) victim = 3'(i);
    end
  end

  always_comb begin
    hit_way = 3'd0;
    for (int i = 0; i < NumWays; i++) begin
      if (way_hit[i]) hit_way = 3'(i);
    end
  end

  assign victim_dirty = valid_out[victim] & dirty_out[victim];

endmodule

// File: rtl/l2_cache_control.sv
// L2 cache controller: hit/miss handling, dirty writeback, line fill and saturating perf counters.
module l2_cache_control
  import pmem_addr_mux::*;
  import data_in_mux::*;
  import data_write_en_mux::*;
  import l2_ctrl_types::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  output logic                   mem_resp,
  output logic                   pmem_read,
  output logic                   pmem_write,
  input  logic                   pmem_resp,
  input  logic                   hit,
  input  logic [NumWays-1:0]     way_hit,
  input  logic [NumWays-1:0]     valid_out,
  input  logic [NumWays-1:0]     dirty_out,
  input  logic [2:0]             plru,
  output logic [NumWays-1:0]     way_load,
  output logic [NumWays-1:0]     valid_load,
  output logic [NumWays-1:0]     valid_in,
  output logic [NumWays-1:0]     dirty_load,
  output logic [NumWays-1:0]     dirty_in,
  output logic                   lru_load,
  output logic [2:0]             mru,
  output logic [2:0]             way_sel,
  output pmem_addr_mux_sel_t     pmem_address_sel,
  output data_in_mux_sel_t       way_data_in_sel [NumWays],
  output data_write_en_mux_sel_t way_write_en_sel [NumWays],
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  l2_state_e   state_q, state_d;
  logic [2:0]  victim_q, victim_d;
  logic        refill_q, refill_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  logic [2:0]  sel_victim;
  logic        sel_victim_dirty;
  logic [2:0]  hit_way;

  l2_victim_sel u_victim_sel (
    .valid_out    (valid_out),
    .dirty_out    (dirty_out),
    .way_hit      (way_hit),
    .plru         (plru),
    .victim       (sel_victim),
    .victim_dirty (sel_victim_dirty),
    .hit_way      (hit_way)
  );

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    refill_d     = refill_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      StIdle: begin
        if (mem_read || mem_write) state_d = StCheck;
      end
      StCheck: begin
        if (hit) begin
          state_d     = StIdle;
          refill_d    = 1'b0;
          hit_count_d = sat_inc(hit_count_q);
        end else begin
          victim_d = sel_victim;
          refill_d = 1'b1;
          // A re-check after a fill belongs to the same request; count the miss once.
          if (!refill_q) miss_count_d = sat_inc(miss_count_q);
          state_d = sel_victim_dirty ? StWriteback : StFill;
        end
      end
      StWriteback: begin
        if (pmem_resp) state_d = StFill;
      end
      StFill: begin
        if (pmem_resp) state_d = StCheck;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      victim_q     <= 3'd0;
      refill_q     <= 1'b0;
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      refill_q     <= refill_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Outputs are held at defaults while rst is high so a coincident pmem_resp writes nothing.
  always_comb begin
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    way_load         = '0;
    valid_load       = '0;
    valid_in         = '0;
    dirty_load       = '0;
    dirty_in         = '0;
    lru_load         = 1'b0;
    mru              = 3'd0;
    way_sel          = 3'd0;
    pmem_address_sel = cpu;
    for (int i = 0; i < NumWays; i++) begin
      way_data_in_sel[i]  = cacheline_adaptor;
      way_write_en_sel[i] = idle;
    end
    if (!rst) begin
      case (state_q)
        StCheck: begin
          if (hit) begin
            mem_resp = 1'b1;
            lru_load = 1'b1;
            mru      = hit_way;
            way_sel  = hit_way;
            if (mem_write) begin
              way_data_in_sel[hit_way]  = bus_adaptor;
              way_write_en_sel[hit_way] = cpu_write;
              dirty_load[hit_way]       = 1'b1;
              dirty_in[hit_way]         = 1'b1;
            end
          end
        end
        StWriteback: begin
          pmem_write       = 1'b1;
          way_sel          = victim_q;
          pmem_address_sel = dirty_write_sel(victim_q);
        end
        StFill: begin
          pmem_read                 = 1'b1;
          way_data_in_sel[victim_q] = cacheline_adaptor;
          if (pmem_resp) begin
            way_write_en_sel[victim_q] = load_mem;
            way_load[victim_q]         = 1'b1;
            valid_load[victim_q]       = 1'b1;
            valid_in[victim_q]         = 1'b1;
            dirty_load[victim_q]       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control: hits, clean/dirty misses, reset abort and counter saturation.
module tb_l2_cache_control;
  import pmem_addr_mux::*;
  import data_in_mux::*;
  import data_write_en_mux::*;
  import l2_ctrl_types::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_read, mem_write, mem_resp;
  logic pmem_read, pmem_write, pmem_resp;
  logic hit;
  logic [7:0] way_hit, valid_out, dirty_out;
  logic [2:0] plru;
  logic [7:0] way_load, valid_load, valid_in, dirty_load, dirty_in;
  logic lru_load;
  logic [2:0] mru, way_sel;
  pmem_addr_mux_sel_t pmem_address_sel;
  data_in_mux_sel_t way_data_in_sel [8];
  data_write_en_mux_sel_t way_write_en_sel [8];
  logic [31:0] hit_count, miss_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  l2_cache_control dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_resp         (mem_resp),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_resp        (pmem_resp),
    .hit              (hit),
    .way_hit          (way_hit),
    .valid_out        (valid_out),
    .dirty_out        (dirty_out),
    .plru             (plru),
    .way_load         (way_load),
    .valid_load       (valid_load),
    .valid_in         (valid_in),
    .dirty_load       (dirty_load),
    .dirty_in         (dirty_in),
    .lru_load         (lru_load),
    .mru              (mru),
    .way_sel          (way_sel),
    .pmem_address_sel (pmem_address_sel),
    .way_data_in_sel  (way_data_in_sel),
    .way_write_en_sel (way_write_en_sel),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0; hit = 1'b0;
    way_hit = 8'h00; valid_out = 8'hFF; dirty_out = 8'h00; plru = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (mem_resp !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_resp got %0b want 0", mem_resp); end
    tests_run++; if ({pmem_read, pmem_write} !== 2'b00) begin tests_failed++; $display("FAIL rst_pmem got %b want 00", {pmem_read, pmem_write}); end
    tests_run++; if (way_load !== 8'h00 || lru_load !== 1'b0) begin tests_failed++; $display("FAIL rst_loads got %h/%b want 00/0", way_load, lru_load); end
    tests_run++; if (pmem_address_sel !== cpu || way_write_en_sel[0] !== idle) begin tests_failed++; $display("FAIL rst_sels got %0d/%0d want 0/0", pmem_address_sel, way_write_en_sel[0]); end
    tests_run++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin tests_failed++; $display("FAIL rst_counts got %0d/%0d want 0/0", hit_count, miss_count); end
  endtask

  task automatic test_read_hit();
    @(negedge clk); mem_read = 1'b1; hit = 1'b1; way_hit = 8'h20; #1;
    tests_run++; if (mem_resp !== 1'b0) begin tests_failed++; $display("FAIL rhit_idle_resp got %0b want 0", mem_resp); end
    @(negedge clk); #1;
    tests_run++; if (mem_resp !== 1'b1) begin tests_failed++; $display("FAIL rhit_resp got %0b want 1", mem_resp); end
    tests_run++; if (mru !== 3'd5 || way_sel !== 3'd5 || lru_load !== 1'b1) begin tests_failed++; $display("FAIL rhit_mru got %0d/%0d/%0b want 5/5/1", mru, way_sel, lru_load); end
    tests_run++; if (dirty_load !== 8'h00 || way_write_en_sel[5] !== idle) begin tests_failed++; $display("FAIL rhit_nowrite got %h/%0d want 00/0", dirty_load, way_write_en_sel[5]); end
    @(negedge clk); idle_inputs(); #1;
    tests_run++; if (mem_resp !== 1'b0 || hit_count !== 32'd1) begin tests_failed++; $display("FAIL rhit_count got %0b/%0d want 0/1", mem_resp, hit_count); end
  endtask

  task automatic test_write_hit();
    @(negedge clk); mem_write = 1'b1; hit = 1'b1; way_hit = 8'h04;
    @(negedge clk); #1;
    tests_run++; if (mem_resp !== 1'b1) begin tests_failed++; $display("FAIL whit_resp got %0b want 1", mem_resp); end
    tests_run++; if (way_write_en_sel[2] !== cpu_write || way_data_in_sel[2] !== bus_adaptor) begin tests_failed++; $display("FAIL whit_sel got %0d/%0d want 2/1", way_write_en_sel[2], way_data_in_sel[2]); end
    tests_run++; if (dirty_load !== 8'h04 || dirty_in !== 8'h04) begin tests_failed++; $display("FAIL whit_dirty got %h/%h want 04/04", dirty_load, dirty_in); end
    tests_run++; if (way_write_en_sel[3] !== idle || way_data_in_sel[3] !== cacheline_adaptor) begin tests_failed++; $display("FAIL whit_other got %0d/%0d want 0/0", way_write_en_sel[3], way_data_in_sel[3]); end
    @(negedge clk); idle_inputs(); #1;
    tests_run++; if (hit_count !== 32'd2) begin tests_failed++; $display("FAIL whit_count got %0d want 2", hit_count); end
  endtask

  task automatic test_clean_miss();
    // Way 3 is invalid but carries a stale dirty bit: still no writeback.
    @(negedge clk); mem_read = 1'b1; valid_out = 8'hF7; dirty_out = 8'hFF; plru = 3'd6;
    @(negedge clk); #1;
    tests_run++; if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin tests_failed++; $display("FAIL cmiss_check got %0b/%0b want 0/0", mem_resp, pmem_read); end
    @(negedge clk); #1;
    tests_run++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address_sel !== cpu) begin tests_failed++; $display("FAIL cmiss_fill got %0b/%0b/%0d want 1/0/0", pmem_read, pmem_write, pmem_address_sel); end
    tests_run++; if (way_load !== 8'h00 || miss_count !== 32'd1) begin tests_failed++; $display("FAIL cmiss_wait got %h/%0d want 00/1", way_load, miss_count); end
    @(negedge clk); pmem_resp = 1'b1; #1;
    tests_run++; if (way_load !== 8'h08 || valid_load !== 8'h08 || valid_in !== 8'h08) begin tests_failed++; $display("FAIL cmiss_load got %h/%h/%h want 08/08/08", way_load, valid_load, valid_in); end
    tests_run++; if (dirty_load !== 8'h08 || dirty_in !== 8'h00 || way_write_en_sel[3] !== load_mem) begin tests_failed++; $display("FAIL cmiss_dirty got %h/%h/%0d want 08/00/1", dirty_load, dirty_in, way_write_en_sel[3]); end
    @(negedge clk); pmem_resp = 1'b0; hit = 1'b1; way_hit = 8'h08; valid_out = 8'hFF; #1;
    tests_run++; if (mem_resp !== 1'b1 || way_sel !== 3'd3 || pmem_read !== 1'b0) begin tests_failed++; $display("FAIL cmiss_recheck got %0b/%0d/%0b want 1/3/0", mem_resp, way_sel, pmem_read); end
    @(negedge clk); idle_inputs(); #1;
    tests_run++; if (miss_count !== 32'd1 || mem_resp !== 1'b0) begin tests_failed++; $display("FAIL cmiss_count got %0d/%0b want 1/0", miss_count, mem_resp); end
  endtask

  task automatic test_dirty_miss();
    @(negedge clk); mem_write = 1'b1; valid_out = 8'hFF; dirty_out = 8'h40; plru = 3'd6;
    @(negedge clk);
    @(negedge clk); #1;
    tests_run++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin tests_failed++; $display("FAIL dmiss_wb got %0b/%0b want 1/0", pmem_write, pmem_read); end
    tests_run++; if (pmem_address_sel !== dirty_6_write || way_sel !== 3'd6) begin tests_failed++; $display("FAIL dmiss_addr got %0d/%0d want 7/6", pmem_address_sel, way_sel); end
    @(negedge clk); #1;
    tests_run++; if (pmem_write !== 1'b1) begin tests_failed++; $display("FAIL dmiss_hold got %0b want 1", pmem_write); end
    @(negedge clk); pmem_resp = 1'b1; #1;
    tests_run++; if (pmem_write !== 1'b1 || way_load !== 8'h00) begin tests_failed++; $display("FAIL dmiss_wbresp got %0b/%h want 1/00", pmem_write, way_load); end
    @(negedge clk); pmem_resp = 1'b0; #1;
    tests_run++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address_sel !== cpu) begin tests_failed++; $display("FAIL dmiss_fill got %0b/%0b/%0d want 1/0/0", pmem_read, pmem_write, pmem_address_sel); end
    @(negedge clk); pmem_resp = 1'b1; #1;
    tests_run++; if (way_load !== 8'h40 || dirty_in !== 8'h00 || dirty_load !== 8'h40) begin tests_failed++; $display("FAIL dmiss_load got %h/%h/%h want 40/00/40", way_load, dirty_in, dirty_load); end
    @(negedge clk); pmem_resp = 1'b0; hit = 1'b1; way_hit = 8'h40; #1;
    tests_run++; if (mem_resp !== 1'b1 || way_write_en_sel[6] !== cpu_write) begin tests_failed++; $display("FAIL dmiss_recheck got %0b/%0d want 1/2", mem_resp, way_write_en_sel[6]); end
    @(negedge clk); idle_inputs(); #1;
    tests_run++; if (miss_count !== 32'd2) begin tests_failed++; $display("FAIL dmiss_count got %0d want 2", miss_count); end
  endtask

  task automatic test_reset_in_fill();
    @(negedge clk); mem_read = 1'b1; valid_out = 8'hF7;
    repeat (3) @(negedge clk);
    // Third fill cycle: reset coincides with the memory response.
    @(negedge clk); rst = 1'b1; pmem_resp = 1'b1; #1;
    tests_run++; if (way_load !== 8'h00 || valid_load !== 8'h00 || way_write_en_sel[3] !== idle) begin tests_failed++; $display("FAIL rfill_noload got %h/%h/%0d want 00/00/0", way_load, valid_load, way_write_en_sel[3]); end
    @(negedge clk); rst = 1'b0; idle_inputs(); #1;
    tests_run++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_resp !== 1'b0) begin tests_failed++; $display("FAIL rfill_idle got %0b/%0b/%0b want 0/0/0", pmem_read, pmem_write, mem_resp); end
    tests_run++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin tests_failed++; $display("FAIL rfill_counts got %0d/%0d want 0/0", hit_count, miss_count); end
    @(negedge clk); #1;
    tests_run++; if (pmem_read !== 1'b0 || way_load !== 8'h00) begin tests_failed++; $display("FAIL rfill_stay got %0b/%h want 0/00", pmem_read, way_load); end
  endtask

  task automatic test_saturation();
    @(negedge clk); dut.hit_count_q = 32'hFFFF_FFFF;
    @(negedge clk); mem_read = 1'b1; hit = 1'b1; way_hit = 8'h02;
    @(negedge clk); #1;
    tests_run++; if (mem_resp !== 1'b1 || mru !== 3'd1) begin tests_failed++; $display("FAIL sat_resp got %0b/%0d want 1/1", mem_resp, mru); end
    @(negedge clk); idle_inputs(); #1;
    tests_run++; if (hit_count !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL sat_count got %h want ffffffff", hit_count); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_reset_in_fill();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
